// File: rtl/vfm_core_link.sv
`default_nettype none
// ============================================================================
// Module   : vfm_core_link
// Brief    : Buffered one-way inter-core message channel. The sender pushes
//            and the receiver pops DATA_W-bit words through toggle
//            handshakes on bit 0 of its ctrl word. A FIFO of 2**ADDR_W
//            entries sits between the two cores.
// Options  : VFM_LINK_STATS_EN - when defined, push_total counts accepted
//            pushes and saturates at 0xFFFF. When undefined, push_total
//            is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vfm_core_link #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 2
) (
  input  logic              Clock_pin,
  input  logic              Resetn_pin,
  input  logic [13:0]       tx_ctrl,
  input  logic [DATA_W-1:0] tx_data,
  output logic [13:0]       tx_stat,
  input  logic [13:0]       rx_ctrl,
  output logic [DATA_W-1:0] rx_data,
  output logic [13:0]       rx_stat,
  output logic [15:0]       push_total
);

  localparam int              c_depth = 1 << ADDR_W;
  // Occupancy value that means "full". The count register is one bit
  // wider than the pointers, so a full FIFO has only the MSB set.
  localparam logic [ADDR_W:0] c_full  = {1'b1, {ADDR_W{1'b0}}};

  // State registers
  logic [DATA_W-1:0] mem_q [c_depth];
  logic [DATA_W-1:0] mem_d [c_depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              tx_tog_q, tx_tog_d;
  logic              rx_tog_q, rx_tog_d;
  logic              udf_q,    udf_d;

  // Handshake decode
  logic w_push_req;
  logic w_pop_req;
  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_underflow;
  logic [3:0] w_count4;

  // Control bits that carry no meaning here. They are gathered into one
  // wire so that the intent is visible.
  logic w_unused;
  assign w_unused = ^{tx_ctrl[13:1], rx_ctrl[13:2]};

  // Request detection and acceptance. A pop that finds the FIFO empty is
  // an underflow even when a push lands on the same edge. A full FIFO
  // accepts a push only if a pop frees a slot on that edge.
  always_comb begin
    w_push_req  = tx_ctrl[0] ^ tx_tog_q;
    w_pop_req   = rx_ctrl[0] ^ rx_tog_q;
    w_empty     = (count_q == '0);
    w_full      = (count_q == c_full);
    w_pop_ok    = w_pop_req && !w_empty;
    w_underflow = w_pop_req && w_empty;
    w_push_ok   = w_push_req && (!w_full || w_pop_ok);
  end

  // Next-state computation for storage, pointers, occupancy, toggles and
  // the underflow flag. The pointers are ADDR_W bits wide and the depth
  // is a power of two, so the increments wrap without extra logic.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tx_tog_d = tx_tog_q;
    rx_tog_d = rx_tog_q;
    udf_d    = udf_q;

    if (w_push_ok) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
      tx_tog_d        = tx_ctrl[0];
    end

    // An underflowing pop is discarded, but its toggle is still echoed.
    if (w_pop_req) begin
      rx_tog_d = rx_ctrl[0];
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // If an underflow and a clear arrive on the same edge, the set wins.
    if (w_underflow) begin
      udf_d = 1'b1;
    end else if (rx_ctrl[1]) begin
      udf_d = 1'b0;
    end
  end

  // Channel state registers. Asserting reset drops all buffered words.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      for (int i = 0; i < c_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_tog_q <= 1'b0;
      rx_tog_q <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < c_depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_tog_q <= tx_tog_d;
      rx_tog_q <= rx_tog_d;
      udf_q    <= udf_d;
    end
  end

  // Status words are driven from registers only, so no input-to-output
  // combinational path exists between the two cores.
  always_comb begin
    w_count4 = 4'(count_q);
    tx_stat  = {7'b0, w_count4, w_empty, w_full, tx_tog_q};
    rx_stat  = {7'b0, w_count4, udf_q, !w_empty, rx_tog_q};
    rx_data  = w_empty ? '0 : mem_q[rd_ptr_q];
  end

`ifdef VFM_LINK_STATS_EN
  logic [15:0] push_total_q, push_total_d;

  // The accepted-push counter holds at its maximum value.
  always_comb begin
    push_total_d = push_total_q;
    if (w_push_ok && (push_total_q != 16'hFFFF)) begin
      push_total_d = push_total_q + 16'd1;
    end
  end

  // Accepted-push counter register
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      push_total_q <= 16'h0;
    end else begin
      push_total_q <= push_total_d;
    end
  end

  assign push_total = push_total_q;
`else
  assign push_total = 16'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vfm_core_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_vfm_core_link
// Brief    : Self-checking bench for vfm_core_link. A queue-based reference
//            model of the channel runs alongside the DUT and is stepped on
//            every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vfm_core_link;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              tx_t, rx_t, rx_clr;
  logic [12:0]       tx_hi;
  logic [11:0]       rx_hi;
  logic [13:0]       tx_ctrl, rx_ctrl;
  logic [DATA_W-1:0] tx_data;
  logic [13:0]       tx_stat, rx_stat;
  logic [DATA_W-1:0] rx_data;
  logic [15:0]       push_total;

  assign tx_ctrl = {tx_hi, tx_t};
  assign rx_ctrl = {rx_hi, rx_clr, rx_t};

  vfm_core_link #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clock_pin  (clk),
    .Resetn_pin (rst_n),
    .tx_ctrl    (tx_ctrl),
    .tx_data    (tx_data),
    .tx_stat    (tx_stat),
    .rx_ctrl    (rx_ctrl),
    .rx_data    (rx_data),
    .rx_stat    (rx_stat),
    .push_total (push_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO modelled as a queue, plus echoes and a flag
  logic [DATA_W-1:0] q[$];
  logic              m_tx_echo, m_rx_echo, m_udf;
  int                m_total;

`ifdef VFM_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic logic [13:0] exp_tx_stat();
    int n = q.size();
    return {7'b0, 4'(n), (n == 0), (n == DEPTH), m_tx_echo};
  endfunction

  function automatic logic [13:0] exp_rx_stat();
    int n = q.size();
    return {7'b0, 4'(n), m_udf, (n != 0), m_rx_echo};
  endfunction

  function automatic logic [DATA_W-1:0] exp_rx_data();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  function automatic logic [15:0] exp_total();
    return STATS ? 16'(m_total) : 16'h0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_tx_echo = 1'b0;
    m_rx_echo = 1'b0;
    m_udf     = 1'b0;
    m_total   = 0;
  endfunction

  // Advance one clock edge and apply the channel rules to the model
  task automatic tick();
    bit push_req, pop_req, pop_ok, push_ok;
    logic [DATA_W-1:0] d;
    logic t_now, r_now, c_now;
    d        = tx_data;
    t_now    = tx_t;
    r_now    = rx_t;
    c_now    = rx_clr;
    push_req = (t_now != m_tx_echo);
    pop_req  = (r_now != m_rx_echo);
    pop_ok   = pop_req && (q.size() > 0);
    push_ok  = push_req && ((q.size() < DEPTH) || pop_ok);
    @(posedge clk);
    if (pop_req) m_rx_echo = r_now;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) begin
      q.push_back(d);
      m_tx_echo = t_now;
      if (m_total < 65535) m_total++;
    end
    if (pop_req && !pop_ok) m_udf = 1'b1;
    else if (c_now) m_udf = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tx_t   = 1'b0;
    rx_t   = 1'b0;
    rx_clr = 1'b0;
    tx_hi  = '0;
    rx_hi  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (tx_stat !== 14'h0004) begin
      n_errors++; $display("FAIL reset_tx_stat got %h exp %h", tx_stat, 14'h0004);
    end
    n_checks++;
    if (rx_stat !== 14'h0000) begin
      n_errors++; $display("FAIL reset_rx_stat got %h exp %h", rx_stat, 14'h0000);
    end
    n_checks++;
    if (rx_data !== '0) begin
      n_errors++; $display("FAIL reset_rx_data got %h exp 0", rx_data);
    end
    n_checks++;
    if (push_total !== 16'h0) begin
      n_errors++; $display("FAIL reset_push_total got %h exp 0", push_total);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    tx_data = 14'h1A5;
    tx_t    = 1'b1;
    tick();
    n_checks++;
    if (tx_stat !== 14'h0009) begin
      n_errors++; $display("FAIL single_tx_stat got %h exp %h", tx_stat, 14'h0009);
    end
    n_checks++;
    if (rx_stat !== 14'h000A) begin
      n_errors++; $display("FAIL single_rx_stat got %h exp %h", rx_stat, 14'h000A);
    end
    n_checks++;
    if (rx_data !== 14'h1A5) begin
      n_errors++; $display("FAIL single_rx_data got %h exp %h", rx_data, 14'h1A5);
    end
    rx_t = 1'b1;
    tick();
    n_checks++;
    if (rx_stat !== 14'h0001 || rx_data !== '0) begin
      n_errors++; $display("FAIL single_pop rx_stat %h rx_data %h exp 0001 0000", rx_stat, rx_data);
    end
    n_checks++;
    if (tx_stat !== 14'h0005) begin
      n_errors++; $display("FAIL single_pop_tx_stat got %h exp %h", tx_stat, 14'h0005);
    end
  endtask

  task automatic test_fill_hold();
    logic [DATA_W-1:0] exp_word;
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      tx_data = DATA_W'(v);
      tx_t    = ~tx_t;
      tick();
    end
    n_checks++;
    if (tx_stat !== exp_tx_stat() || tx_stat[1] !== 1'b1) begin
      n_errors++; $display("FAIL fill_full got %h exp %h", tx_stat, exp_tx_stat());
    end
    tx_data = 14'h005;
    tx_t    = ~tx_t;
    tick();
    tick();
    n_checks++;
    if (tx_stat[0] === tx_t || tx_stat !== exp_tx_stat()) begin
      n_errors++; $display("FAIL fill_pending_held got %h exp %h", tx_stat, exp_tx_stat());
    end
    rx_t = ~rx_t;
    tick();
    n_checks++;
    if (tx_stat[0] !== tx_t || tx_stat[6:3] !== 4'd4) begin
      n_errors++; $display("FAIL fill_accept_on_pop got %h exp echo %b count 4", tx_stat, tx_t);
    end
    for (int i = 0; i < 4; i++) begin
      exp_word = DATA_W'(2 + i);
      n_checks++;
      if (rx_data !== exp_word) begin
        n_errors++; $display("FAIL fill_drain_%0d got %h exp %h", i, rx_data, exp_word);
      end
      rx_t = ~rx_t;
      tick();
    end
    n_checks++;
    if (rx_stat !== exp_rx_stat() || rx_data !== '0) begin
      n_errors++; $display("FAIL fill_drained rx_stat %h exp %h rx_data %h", rx_stat, exp_rx_stat(), rx_data);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] w;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      w       = DATA_W'($urandom);
      tx_data = w;
      tx_t    = ~tx_t;
      tick();
      n_checks++;
      if (rx_data !== w || tx_stat[6:3] > 4'd1 || tx_stat !== exp_tx_stat()) begin
        n_errors++; $display("FAIL wrap_%0d rx_data %h exp %h tx_stat %h exp %h", i, rx_data, w, tx_stat, exp_tx_stat());
      end
      rx_t = ~rx_t;
      tick();
      n_checks++;
      if (rx_stat !== exp_rx_stat()) begin
        n_errors++; $display("FAIL wrap_pop_%0d rx_stat %h exp %h", i, rx_stat, exp_rx_stat());
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    rx_t = 1'b1;
    tick();
    n_checks++;
    if (rx_stat !== 14'h0005 || tx_stat !== 14'h0004) begin
      n_errors++; $display("FAIL udf_set rx_stat %h exp 0005 tx_stat %h exp 0004", rx_stat, tx_stat);
    end
    tx_data = 14'h3FF;
    tx_t    = 1'b1;
    tick();
    n_checks++;
    if (rx_data !== 14'h3FF || rx_stat !== exp_rx_stat()) begin
      n_errors++; $display("FAIL udf_push_kept rx_data %h exp 03ff rx_stat %h exp %h", rx_data, rx_stat, exp_rx_stat());
    end
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    n_checks++;
    if (rx_stat[2] !== 1'b0 || rx_stat !== exp_rx_stat()) begin
      n_errors++; $display("FAIL udf_clear rx_stat %h exp %h", rx_stat, exp_rx_stat());
    end
    // Underflow coinciding with a clear: the set must win
    rx_t = ~rx_t;
    tick();
    rx_t   = ~rx_t;
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    n_checks++;
    if (rx_stat[2] !== 1'b1 || rx_stat !== exp_rx_stat()) begin
      n_errors++; $display("FAIL udf_set_wins rx_stat %h exp %h", rx_stat, exp_rx_stat());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ((tx_t == m_tx_echo) && ($urandom_range(0, 1) == 1)) begin
        tx_data = DATA_W'($urandom);
        tx_t    = ~tx_t;
      end
      if ($urandom_range(0, 2) == 0) rx_t = ~rx_t;
      rx_clr = ($urandom_range(0, 7) == 0);
      tx_hi  = 13'($urandom);
      rx_hi  = 12'($urandom);
      tick();
      n_checks++;
      if (tx_stat !== exp_tx_stat() || rx_stat !== exp_rx_stat() ||
          rx_data !== exp_rx_data() || push_total !== exp_total()) begin
        n_errors++;
        $display("FAIL random_%0d tx %h/%h rx %h/%h data %h/%h total %h/%h", i,
                 tx_stat, exp_tx_stat(), rx_stat, exp_rx_stat(),
                 rx_data, exp_rx_data(), push_total, exp_total());
      end
    end
    tx_hi  = '0;
    rx_hi  = '0;
    rx_clr = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int v = 0; v < 3; v++) begin
      tx_data = DATA_W'(14'h100 + v);
      tx_t    = ~tx_t;
      tick();
    end
    n_checks++;
    if (tx_stat[6:3] !== 4'd3) begin
      n_errors++; $display("FAIL midop_prefill count %0d exp 3", tx_stat[6:3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_stat !== 14'h0004 || rx_data !== '0 || rx_stat !== 14'h0000) begin
      n_errors++; $display("FAIL midop_async tx_stat %h exp 0004 rx_data %h exp 0 rx_stat %h exp 0", tx_stat, rx_data, rx_stat);
    end
    tx_t = 1'b0;
    rx_t = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (tx_stat !== exp_tx_stat() || rx_data !== exp_rx_data()) begin
      n_errors++; $display("FAIL midop_after tx_stat %h exp %h rx_data %h", tx_stat, exp_tx_stat(), rx_data);
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int v = 0; v < 4; v++) begin
      tx_data = DATA_W'(14'h20 + v);
      tx_t    = ~tx_t;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      rx_t = ~rx_t;
      tick();
    end
    for (int v = 0; v < 2; v++) begin
      tx_data = DATA_W'(14'h30 + v);
      tx_t    = ~tx_t;
      tick();
    end
    tx_data = 14'h3A;
    tx_t    = ~tx_t;
    repeat (3) tick();
    n_checks++;
    if (tx_stat[0] === tx_t) begin
      n_errors++; $display("FAIL stats_pending echo %b exp %b", tx_stat[0], ~tx_t);
    end
    n_checks++;
    if (push_total !== (STATS ? 16'd6 : 16'd0)) begin
      n_errors++; $display("FAIL stats_total got %0d exp %0d", push_total, (STATS ? 6 : 0));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    tx_t    = 1'b0;
    rx_t    = 1'b0;
    rx_clr  = 1'b0;
    tx_hi   = '0;
    rx_hi   = '0;
    tx_data = '0;
    model_reset();
    test_reset();
    test_single_word();
    test_fill_hold();
    test_wrap();
    test_underflow();
    test_random();
    test_reset_midop();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
